prf_freelist_ctrl: RTL and testbench

// - Controls the physical-register free list, a QUEUE_obj instance with INIT=0, SPECIAL=0, LENGTH=FL_DEPTH, WIDTH=PTAG_W.
// - Grants physical tags to rename and returns retired tags to the queue.
// - After reset, fills the queue with tags NUM_ARCH..NUM_PHYS-1.
// - After a flush, rebuilds the queue from the committed map by walking all tags, one tag per cycle.
// - Maintains a free-tag counter that mirrors the queue occupancy.

---
 rtl/prf_freelist_ctrl.sv | 135 +++++++++++++
 tb/tb_prf_freelist_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_freelist_ctrl.sv
// Physical-register free-list controller: grants tags to rename, returns retired tags,
// fills the free-list queue after reset and rebuilds it from the committed map after a flush.
module prf_freelist_ctrl #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int PTAG_W   = $clog2(NUM_PHYS),
    parameter int FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_ARCH*PTAG_W-1:0] comm_map,
    input  logic                       alloc_req,
    input  logic                       rename_stall,
    output logic                       alloc_gnt,
    output logic [PTAG_W-1:0]          alloc_ptag,
    input  logic                       rel_valid,
    input  logic [PTAG_W-1:0]          rel_ptag,
    output logic                       busy,
    output logic [PTAG_W:0]            free_cnt,
    output logic                       fl_flush,
    output logic                       fl_enque,
    output logic [PTAG_W-1:0]          fl_enque_data,
    output logic                       fl_deque,
    input  logic [PTAG_W-1:0]          fl_deque_data
);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RECOVER
    } state_t;

    localparam logic [PTAG_W:0] DEPTH_C = (PTAG_W+1)'(FL_DEPTH);
    localparam logic [PTAG_W:0] LAST_C  = (PTAG_W+1)'(NUM_PHYS - 1);
    localparam logic [PTAG_W:0] ARCH_C  = (PTAG_W+1)'(NUM_ARCH);
    localparam logic [PTAG_W:0] ONE_C   = (PTAG_W+1)'(1);

    state_t                state_q, state_d;
    logic [PTAG_W:0]       idx_q, idx_d;
    logic [PTAG_W:0]       free_cnt_q, free_cnt_d;
    logic [NUM_PHYS-1:0]   in_use_q, in_use_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            idx_q      <= ARCH_C;
            free_cnt_q <= '0;
            in_use_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            free_cnt_q <= free_cnt_d;
            in_use_q   <= in_use_d;
        end
    end

    // Outputs are forced low while reset is asserted, even though the state already reads INIT.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        free_cnt_d    = free_cnt_q;
        in_use_d      = in_use_q;
        alloc_gnt     = 1'b0;
        alloc_ptag    = '0;
        fl_flush      = 1'b0;
        fl_enque      = 1'b0;
        fl_enque_data = '0;
        fl_deque      = 1'b0;

        if (!reset) begin
            state_d = INIT;
        end else if (flush) begin
            fl_flush = 1'b1;
            in_use_d = '0;
            for (int k = 0; k < NUM_ARCH; k++) begin
                in_use_d[comm_map[k*PTAG_W +: PTAG_W]] = 1'b1;
            end
            idx_d      = '0;
            free_cnt_d = '0;
            state_d    = RECOVER;
        end else begin
            case (state_q)
                INIT: begin
                    fl_enque      = 1'b1;
                    fl_enque_data = idx_q[PTAG_W-1:0];
                    idx_d         = idx_q + ONE_C;
                    free_cnt_d    = free_cnt_q + ONE_C;
                    if (idx_q == LAST_C) begin
                        state_d = RUN;
                    end
                end
                RECOVER: begin
                    fl_enque      = ~in_use_q[idx_q[PTAG_W-1:0]];
                    fl_enque_data = idx_q[PTAG_W-1:0];
                    idx_d         = idx_q + ONE_C;
                    if (fl_enque) begin
                        free_cnt_d = free_cnt_q + ONE_C;
                    end
                    if (idx_q == LAST_C) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    alloc_gnt  = alloc_req & ~rename_stall & (free_cnt_q != '0);
                    fl_deque   = alloc_gnt;
                    alloc_ptag = alloc_gnt ? fl_deque_data : '0;
                    // A release into a full list is only accepted when a grant frees a slot.
                    fl_enque      = rel_valid & ((free_cnt_q != DEPTH_C) | alloc_gnt);
                    fl_enque_data = fl_enque ? rel_ptag : '0;
                    if (fl_enque && !alloc_gnt) begin
                        free_cnt_d = free_cnt_q + ONE_C;
                    end else if (alloc_gnt && !fl_enque) begin
                        free_cnt_d = free_cnt_q - ONE_C;
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

    assign busy     = (state_q != RUN);
    assign free_cnt = free_cnt_q;

`ifdef QUEUE
    always_ff @(posedge clk) begin
        if (reset && !flush && state_q == RUN) begin
            assert (!(rel_valid && free_cnt_q == DEPTH_C && !alloc_gnt));
        end
    end
`endif

endmodule

// File: tb/tb_prf_freelist_ctrl.sv
// Self-checking bench for prf_freelist_ctrl: models the free-list queue and the controller's
// fill / walk / run behaviour with plain queues and counters.
module tb_prf_freelist_ctrl;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PTAG_W   = 6;
    localparam int FL_DEPTH = 32;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       flush = 1'b0;
    logic [NUM_ARCH*PTAG_W-1:0] comm_map = '0;
    logic                       alloc_req = 1'b0;
    logic                       rename_stall = 1'b0;
    logic                       alloc_gnt;
    logic [PTAG_W-1:0]          alloc_ptag;
    logic                       rel_valid = 1'b0;
    logic [PTAG_W-1:0]          rel_ptag = '0;
    logic                       busy;
    logic [PTAG_W:0]            free_cnt;
    logic                       fl_flush;
    logic                       fl_enque;
    logic [PTAG_W-1:0]          fl_enque_data;
    logic                       fl_deque;
    logic [PTAG_W-1:0]          fl_deque_data = '0;

    always #5 clk = ~clk;

    prf_freelist_ctrl #(
        .NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH), .PTAG_W(PTAG_W), .FL_DEPTH(FL_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .comm_map(comm_map),
        .alloc_req(alloc_req), .rename_stall(rename_stall),
        .alloc_gnt(alloc_gnt), .alloc_ptag(alloc_ptag),
        .rel_valid(rel_valid), .rel_ptag(rel_ptag),
        .busy(busy), .free_cnt(free_cnt),
        .fl_flush(fl_flush), .fl_enque(fl_enque), .fl_enque_data(fl_enque_data),
        .fl_deque(fl_deque), .fl_deque_data(fl_deque_data)
    );

    typedef enum {M_FILL, M_WALK, M_RUN} mode_t;

    typedef struct {
        logic              req;
        logic              stall;
        logic              rv;
        logic [PTAG_W-1:0] rp;
        logic              e_gnt;
        logic [PTAG_W-1:0] e_ptag;
        int                e_cnt;
    } vec_t;

    // Reference model: the free list as a queue plus the current fill/walk position.
    mode_t             m_mode;
    int                m_pos;
    logic [PTAG_W-1:0] mq[$];
    bit                m_mapped[NUM_PHYS];

    // The free-list queue the DUT actually drives.
    logic [PTAG_W-1:0] env_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic              s_gnt, s_enq, s_flush, s_busy;
    logic [PTAG_W-1:0] s_ptag, s_data;
    int                s_cnt;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_mode = M_FILL;
        m_pos  = NUM_ARCH;
        mq.delete();
        env_q.delete();
        fl_deque_data = '0;
    endtask

    // One clock cycle: drive inputs at the negedge, compare at +1, advance both queues at the posedge.
    task automatic applyStimulus(input logic f, input logic req, input logic st,
                                 input logic rv, input logic [PTAG_W-1:0] rp);
        logic              e_gnt, e_enq;
        logic [PTAG_W-1:0] e_ptag, e_data;
        int                e_cnt;
        logic              a_deq;
        flush = f; alloc_req = req; rename_stall = st; rel_valid = rv; rel_ptag = rp;
        #1;
        e_gnt = 1'b0; e_enq = 1'b0; e_ptag = '0; e_data = '0;
        e_cnt = mq.size();
        if (f) begin
            e_enq = 1'b0;
        end else if (m_mode == M_FILL) begin
            e_enq = 1'b1; e_data = m_pos[PTAG_W-1:0];
        end else if (m_mode == M_WALK) begin
            e_enq = !m_mapped[m_pos]; e_data = m_pos[PTAG_W-1:0];
        end else begin
            e_gnt = req && !st && (mq.size() != 0);
            if (e_gnt) e_ptag = mq[0];
            e_enq  = rv && (mq.size() < FL_DEPTH || e_gnt);
            e_data = rp;
        end
        s_gnt = alloc_gnt; s_ptag = alloc_ptag; s_enq = fl_enque; s_data = fl_enque_data;
        s_flush = fl_flush; s_busy = busy; s_cnt = int'(free_cnt); a_deq = fl_deque;
        checkOutput("busy", s_busy, (m_mode != M_RUN));
        checkOutput("free_cnt", s_cnt, e_cnt);
        checkOutput("alloc_gnt", s_gnt, e_gnt);
        checkOutput("fl_deque", a_deq, e_gnt);
        checkOutput("fl_flush", s_flush, f);
        checkOutput("fl_enque", s_enq, e_enq);
        if (e_gnt && s_gnt) checkOutput("alloc_ptag", s_ptag, e_ptag);
        if (e_enq && s_enq) checkOutput("fl_enque_data", s_data, e_data);
        @(posedge clk);
        if (s_flush) begin
            env_q.delete();
        end else begin
            if (a_deq && env_q.size() != 0) void'(env_q.pop_front());
            if (s_enq) env_q.push_back(s_data);
        end
        if (f) begin
            mq.delete();
            foreach (m_mapped[t]) m_mapped[t] = 1'b0;
            for (int k = 0; k < NUM_ARCH; k++) m_mapped[comm_map[k*PTAG_W +: PTAG_W]] = 1'b1;
            m_pos  = 0;
            m_mode = M_WALK;
        end else if (m_mode == M_RUN) begin
            if (e_gnt) void'(mq.pop_front());
            if (e_enq) mq.push_back(e_data);
        end else begin
            if (e_enq) mq.push_back(e_data);
            m_pos++;
            if (m_pos == NUM_PHYS) m_mode = M_RUN;
        end
        #1;
        fl_deque_data = (env_q.size() != 0) ? env_q[0] : '0;
        @(negedge clk);
    endtask

    // Async reset with hostile inputs: every output must read zero except busy.
    task automatic resetDut();
        reset = 1'b0; flush = 1'b1; alloc_req = 1'b1; rel_valid = 1'b1; rel_ptag = 6'd9;
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_free_cnt", free_cnt, 0);
        checkOutput("rst_alloc_gnt", alloc_gnt, 0);
        checkOutput("rst_fl_flush", fl_flush, 0);
        checkOutput("rst_fl_enque", fl_enque, 0);
        checkOutput("rst_fl_deque", fl_deque, 0);
        modelReset();
        @(negedge clk);
        flush = 1'b0; alloc_req = 1'b0; rel_valid = 1'b0; rel_ptag = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic randomPermMap();
        int arr[NUM_PHYS];
        int j, tmp;
        for (int i = 0; i < NUM_PHYS; i++) arr[i] = i;
        for (int i = NUM_PHYS - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = arr[i]; arr[i] = arr[j]; arr[j] = tmp;
        end
        for (int k = 0; k < NUM_ARCH; k++) comm_map[k*PTAG_W +: PTAG_W] = arr[k][PTAG_W-1:0];
    endtask

    function automatic int distinctTags();
        bit seen[NUM_PHYS];
        int n = 0;
        for (int k = 0; k < NUM_ARCH; k++) begin
            if (!seen[comm_map[k*PTAG_W +: PTAG_W]]) n++;
            seen[comm_map[k*PTAG_W +: PTAG_W]] = 1'b1;
        end
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   walk_enq, guard, cyc, exp_free;
        bit   saw3, saw40;

        // Full list: a release alongside a grant is legal; then a stall delays the 34 grant.
        vecs[0] = '{req:1, stall:0, rv:1, rp:6'd7, e_gnt:1, e_ptag:6'd32, e_cnt:32};
        vecs[1] = '{req:1, stall:0, rv:0, rp:6'd0, e_gnt:1, e_ptag:6'd33, e_cnt:32};
        vecs[2] = '{req:1, stall:1, rv:0, rp:6'd0, e_gnt:0, e_ptag:6'd0,  e_cnt:31};
        vecs[3] = '{req:1, stall:0, rv:0, rp:6'd0, e_gnt:1, e_ptag:6'd34, e_cnt:31};
        vecs[4] = '{req:0, stall:0, rv:0, rp:6'd0, e_gnt:0, e_ptag:6'd0,  e_cnt:30};

        resetDut();

        for (int i = 0; i < FL_DEPTH; i++) applyStimulus(0, 0, 0, 0, '0);
        checkOutput("init_done_busy", busy, 0);
        checkOutput("init_done_free_cnt", free_cnt, 32);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].req, vecs[i].stall, vecs[i].rv, vecs[i].rp);
            checkOutput($sformatf("vec%0d_gnt", i), s_gnt, vecs[i].e_gnt);
            checkOutput($sformatf("vec%0d_cnt", i), s_cnt, vecs[i].e_cnt);
            if (vecs[i].e_gnt) checkOutput($sformatf("vec%0d_ptag", i), s_ptag, vecs[i].e_ptag);
        end

        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            applyStimulus(0, 1, 0, 0, '0);
            guard++;
        end
        checkOutput("drain_free_cnt", free_cnt, 0);
        applyStimulus(0, 1, 0, 1, 6'd5);
        checkOutput("nobypass_gnt", s_gnt, 0);
        checkOutput("nobypass_cnt_after", free_cnt, 1);
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("late_gnt", s_gnt, 1);
        checkOutput("late_ptag", s_ptag, 5);
        checkOutput("late_cnt_after", free_cnt, 0);

        for (int k = 0; k < NUM_ARCH; k++) comm_map[k*PTAG_W +: PTAG_W] = k[PTAG_W-1:0];
        comm_map[3*PTAG_W +: PTAG_W] = 6'd40;
        applyStimulus(1, 1, 0, 1, 6'd12);
        checkOutput("flush_pulse", s_flush, 1);
        walk_enq = 0; saw3 = 0; saw40 = 0;
        for (int c = 0; c < NUM_PHYS; c++) begin
            applyStimulus(0, 1, 0, 1, 6'd12);
            if (s_enq) begin
                walk_enq++;
                if (s_data == 6'd3)  saw3 = 1;
                if (s_data == 6'd40) saw40 = 1;
            end
        end
        checkOutput("walk_enq_count", walk_enq, 32);
        checkOutput("walk_has_3", saw3, 1);
        checkOutput("walk_has_40", saw40, 0);
        checkOutput("walk_done_busy", busy, 0);
        checkOutput("walk_done_free_cnt", free_cnt, 32);

        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, '0);
        randomPermMap();
        exp_free = NUM_PHYS - distinctTags();
        applyStimulus(1, 0, 0, 1, mq[0]);
        checkOutput("flush_rel_enque", s_enq, 0);
        for (int c = 0; c < NUM_PHYS; c++) applyStimulus(0, 0, 0, 0, '0);
        checkOutput("flush_rel_free_cnt", free_cnt, exp_free);

        applyStimulus(1, 0, 0, 0, '0);
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, '0);
        randomPermMap();
        applyStimulus(1, 0, 0, 0, '0);
        cyc = 0;
        while (busy && cyc < 200) begin
            applyStimulus(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 6'($urandom));
            cyc++;
        end
        checkOutput("rewalk_len", cyc, 64);

        for (int c = 0; c < 40; c++) applyStimulus(0, 1, $urandom_range(0, 1), 0, '0);
        resetDut();
        for (int c = 0; c < 900; c++) begin
            logic f, rv;
            f = ($urandom_range(0, 59) == 0);
            if (f) randomPermMap();
            rv = $urandom_range(0, 1);
            if (m_mode == M_RUN && mq.size() >= FL_DEPTH) rv = 1'b0;
            applyStimulus(f, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), rv, 6'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
